// File: rtl/audio_pkg.sv
// Shared audio definitions for the synthesiser and the codec interface.
// Both the oscillator side and the I2S transmitter pull their default
// widths and the frame length from here so the two stay in step.
package audio_pkg;

    // Default sample width produced by the synth.
    localparam int DATA_W_DEFAULT   = 16;
    // Default number of bit clocks per channel slot.
    localparam int SLOT_W_DEFAULT   = 16;
    // Default number of system clocks per BCLK half-period.
    localparam int BCLK_DIV_DEFAULT = 4;

    // System clocks per stereo frame: two slots, SLOT_W bits each,
    // and every bit lasts 2*BCLK_DIV system clocks.
    localparam int FRAME_CYCLES = 4 * SLOT_W_DEFAULT * BCLK_DIV_DEFAULT;

    // Mono sample as produced by the synth, signed two's complement.
    typedef logic signed [DATA_W_DEFAULT-1:0] sample_t;

endpackage

// File: rtl/i2s_timing_gen.sv
// Bit-clock and bit-position generator for the I2S transmitter.
// Divides the system clock down to BCLK and tracks which bit of the
// stereo frame is on the wire. The strobes describe what the coming
// clock edge will do, so the parent can register its outputs on the
// same edge that moves BCLK low.
module i2s_timing_gen
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = BCLK_DIV_DEFAULT,
    parameter int SLOT_W   = SLOT_W_DEFAULT,
    localparam int FRAME_BITS = 2 * SLOT_W,
    localparam int BIT_W      = $clog2(FRAME_BITS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic             o_bclk,
    output logic             o_fall_stb,
    output logic             o_frame_stb,
    output logic [BIT_W-1:0] o_bit_next
);

    localparam int CNT_W = $clog2(BCLK_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             fall_d;

    // Next-state for the divider, BCLK and bit position; idle returns
    // everything to the reset values so a re-enable starts a fresh frame.
    always_comb begin
        div_cnt_d = div_cnt_q;
        bclk_d    = bclk_q;
        bit_cnt_d = bit_cnt_q;
        fall_d    = 1'b0;
        if (!i_en) begin
            div_cnt_d = '0;
            bclk_d    = 1'b0;
            bit_cnt_d = BIT_LAST;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
            if (bclk_q) begin
                fall_d    = 1'b1;
                bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
            end
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    // Timing state register with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= BIT_LAST;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign o_bclk      = bclk_q;
    assign o_fall_stb  = fall_d;
    assign o_bit_next  = bit_cnt_d;
    assign o_frame_stb = fall_d && (bit_cnt_d == '0);

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S master transmitter feeding the codec DAC.
// Latches one mono sample per frame, duplicates it into the left and
// right slots and shifts it out MSB first with the standard one-bit
// delay after LRCK changes. The per-frame tick paces the synth.
module i2s_dac_tx
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = BCLK_DIV_DEFAULT,
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int SLOT_W   = SLOT_W_DEFAULT
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_audio,
    output logic                     o_bclk,
    output logic                     o_lrck,
    output logic                     o_dacdat,
    output logic                     o_sample_tick
);

    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int PAD_W      = SLOT_W - DATA_W;

    logic             fall_stb;
    logic             frame_stb;
    logic [BIT_W-1:0] bit_next;

    logic [DATA_W-1:0]     sample_q, sample_d;
    logic                  lrck_q, lrck_d;
    logic                  dacdat_q, dacdat_d;
    logic                  tick_q, tick_d;
    logic [SLOT_W-1:0]     slot_word;
    logic [FRAME_BITS-1:0] frame_word;
    logic [BIT_W-1:0]      word_idx;

    i2s_timing_gen #(
        .BCLK_DIV (BCLK_DIV),
        .SLOT_W   (SLOT_W)
    ) u_timing (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .o_bclk      (o_bclk),
        .o_fall_stb  (fall_stb),
        .o_frame_stb (frame_stb),
        .o_bit_next  (bit_next)
    );

    // Build the frame word from the latched sample and pick the bit for
    // the coming position; bit 0 of the frame lands in the next frame's
    // first position, which is what gives the one-bit delay.
    always_comb begin
        slot_word  = SLOT_W'(sample_q) << PAD_W;
        frame_word = {slot_word, slot_word};
        word_idx   = '0;
        if (bit_next != '0) begin
            word_idx = BIT_W'(FRAME_BITS - int'(bit_next));
        end
    end

    // Next-state for the word select, serial data, sample latch and tick.
    always_comb begin
        sample_d = sample_q;
        lrck_d   = lrck_q;
        dacdat_d = dacdat_q;
        tick_d   = 1'b0;
        if (!i_en) begin
            sample_d = '0;
            lrck_d   = 1'b0;
            dacdat_d = 1'b0;
        end else begin
            tick_d = frame_stb;
            if (fall_stb) begin
                lrck_d   = (bit_next >= BIT_W'(SLOT_W));
                dacdat_d = frame_word[word_idx];
            end
            if (frame_stb) begin
                sample_d = i_audio;
            end
        end
    end

    // Output and sample registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sample_q <= '0;
            lrck_q   <= 1'b0;
            dacdat_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            sample_q <= sample_d;
            lrck_q   <= lrck_d;
            dacdat_q <= dacdat_d;
            tick_q   <= tick_d;
        end
    end

    assign o_lrck        = lrck_q;
    assign o_dacdat      = dacdat_q;
    assign o_sample_tick = tick_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for the I2S DAC transmitter.
// Samples pushed by the stimulus are matched against the frames seen on
// the serial pins; BCLK, LRCK and tick timing come from an arithmetic
// model driven by the number of enabled clock edges.
module tb_i2s_dac_tx;
    import audio_pkg::*;

    localparam int DIV       = BCLK_DIV_DEFAULT;
    localparam int SLOT      = SLOT_W_DEFAULT;
    localparam int DW        = DATA_W_DEFAULT;
    localparam int FB        = 2 * SLOT;
    localparam int BCLK_CYC  = 2 * DIV;
    localparam int FRAME_CYC = FRAME_CYCLES;
    localparam int SLOT24    = 24;

    logic    clk;
    logic    rst, en;
    sample_t audio;
    logic    bclk, lrck, dacdat, tick;
    logic    rst24, en24;
    sample_t audio24;
    logic    bclk24, lrck24, dacdat24, tick24;

    int compared   = 0;
    int mismatched = 0;
    int enCycles;
    logic [15:0] expQ[$];

    i2s_dac_tx #(.BCLK_DIV(DIV), .DATA_W(DW), .SLOT_W(SLOT)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_audio(audio),
        .o_bclk(bclk), .o_lrck(lrck), .o_dacdat(dacdat), .o_sample_tick(tick)
    );

    i2s_dac_tx #(.BCLK_DIV(DIV), .DATA_W(DW), .SLOT_W(SLOT24)) dut24 (
        .i_clk(clk), .i_rst(rst24), .i_en(en24), .i_audio(audio24),
        .o_bclk(bclk24), .o_lrck(lrck24), .o_dacdat(dacdat24), .o_sample_tick(tick24)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Enabled edges since the last reset or idle cycle drive the model.
    always @(posedge clk or posedge rst) begin
        if (rst) enCycles <= 0;
        else if (en) enCycles <= enCycles + 1;
        else enCycles <= 0;
    end

    function automatic logic expBclk(input int e);
        return ((e / DIV) % 2) == 1;
    endfunction

    function automatic logic expTick(input int e);
        return (e > 0) && (e % BCLK_CYC == 0) && (((e / BCLK_CYC) - 1) % FB == 0);
    endfunction

    function automatic logic expLrck(input int e);
        int f;
        f = e / BCLK_CYC;
        if (f == 0) return 1'b0;
        return ((f - 1) % FB) >= SLOT;
    endfunction

    function automatic int tickEdge(input int k);
        return BCLK_CYC + k * FRAME_CYC;
    endfunction

    function automatic logic [63:0] expFrame(input logic [63:0] s, input int slotW, input int dataW);
        logic [63:0] slot;
        slot = s << (slotW - dataW);
        return (slot << slotW) | slot;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] v);
        audio = v;
        expQ.push_back(v);
    endtask

    task automatic waitUntilE(input int target);
        while (enCycles < target) @(negedge clk);
    endtask

    // Monitor: per-cycle timing checks plus frame capture on BCLK rising.
    initial begin
        logic        prevBclk;
        int          j;
        bit          active, pending;
        logic [15:0] curExp, nextExp;
        logic [63:0] word;
        prevBclk = 1'b0; j = 0; active = 0; pending = 0;
        curExp = '0; nextExp = '0; word = '0;
        forever begin
            @(negedge clk);
            if (rst || enCycles == 0) begin
                checkOutput("idle outputs", {60'd0, bclk, lrck, dacdat, tick}, 64'd0);
                active = 0; pending = 0; j = 0;
            end else begin
                checkOutput("bclk", bclk, expBclk(enCycles));
                checkOutput("lrck", lrck, expLrck(enCycles));
                checkOutput("tick", tick, expTick(enCycles));
                if (bclk && !prevBclk) begin
                    j++;
                    if (j == 1) begin
                        if (active) begin
                            word = {word[62:0], dacdat};
                            checkOutput($sformatf("frame %04h", curExp), word, expFrame(64'(curExp), SLOT, DW));
                        end
                        active = pending; curExp = nextExp; pending = 0; word = '0;
                    end else if (active) begin
                        word = {word[62:0], dacdat};
                    end
                end
                if (tick) begin
                    checkOutput("queue has entry at tick", 64'(expQ.size() > 0), 64'd1);
                    if (expQ.size() > 0) begin
                        nextExp = expQ.pop_front();
                        pending = 1;
                    end
                    j = 0;
                end
            end
            prevBclk = bclk;
        end
    end

    // Stimulus sequence.
    initial begin
        int guard, rises;
        logic prev;
        logic [63:0] word24;
        rst = 1'b1; en = 1'b1; audio = '0;
        rst24 = 1'b1; en24 = 1'b0; audio24 = '0;
        repeat (200) @(negedge clk);

        $display("[TB] enable with default slots");
        applyStimulus(16'hA5C3);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            waitUntilE(tickEdge(k) + int'($urandom_range(4, 200)));
            if (k == 0) applyStimulus(16'h7FFF);
            else if (k == 1) applyStimulus(16'h8000);
            else applyStimulus(16'($urandom));
        end

        $display("[TB] drop enable mid-frame");
        waitUntilE(tickEdge(8) + 10 * BCLK_CYC + 2);
        en = 1'b0;
        repeat (6) @(negedge clk);
        applyStimulus(16'($urandom));
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            waitUntilE(tickEdge(k) + int'($urandom_range(4, 200)));
            applyStimulus(16'($urandom));
        end
        waitUntilE(tickEdge(4) + 4);
        checkOutput("queue drained", 64'(expQ.size()), 64'd0);
        en = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] 24-bit slots with 16-bit sample");
        audio24 = 16'sh0001; rst24 = 1'b0; en24 = 1'b1;
        guard = 0;
        while (!tick24 && guard < 4 * BCLK_CYC) begin
            @(negedge clk); guard++;
        end
        checkOutput("slot24 first tick", tick24, 1'b1);
        rises = 0; word24 = '0; prev = bclk24; guard = 0;
        while (rises < 2 * SLOT24 + 1 && guard < (2 * SLOT24 + 4) * BCLK_CYC) begin
            @(negedge clk); guard++;
            if (bclk24 && !prev) begin
                rises++;
                if (rises >= 2) word24 = {word24[62:0], dacdat24};
            end
            prev = bclk24;
        end
        checkOutput("slot24 frame", word24, expFrame(64'h1, SLOT24, DW));
        guard = 0;
        while (!bclk24 && guard < 4 * BCLK_CYC) begin
            @(negedge clk); guard++;
        end
        checkOutput("slot24 bclk high before reset", bclk24, 1'b1);
        #1 rst24 = 1'b1;
        #1 checkOutput("slot24 async reset", {60'd0, bclk24, lrck24, dacdat24, tick24}, 64'd0);
        @(negedge clk);
        en24 = 1'b0; rst24 = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
